// File: rtl/breakout_hit_arbiter_if.sv
// Column-side bus of the breakout hit arbiter: per-column hit requests and
// score counts in, registered bounce command and last granted column out.
interface breakout_hit_arbiter_if #(
  parameter int unsigned NCOL  = 8,
  parameter int unsigned CNT_W = 6
) ();
  logic [NCOL-1:0]       col_hit_u;
  logic [NCOL-1:0]       col_hit_d;
  logic [NCOL-1:0]       col_hit_l;
  logic [NCOL-1:0]       col_hit_r;
  logic [NCOL*CNT_W-1:0] col_count;
  logic                  bounce_u;
  logic                  bounce_d;
  logic                  bounce_l;
  logic                  bounce_r;
  logic [2:0]            grant_col;

  modport master (
    output col_hit_u, col_hit_d, col_hit_l, col_hit_r, col_count,
    input  bounce_u, bounce_d, bounce_l, bounce_r, grant_col
  );

  modport slave (
    input  col_hit_u, col_hit_d, col_hit_l, col_hit_r, col_count,
    output bounce_u, bounce_d, bounce_l, bounce_r, grant_col
  );
endinterface

// File: rtl/breakout_hit_arbiter.sv
// Breakout game sequencer: one round-robin bounce grant per frame, saturating
// score total, and the serve/play/lose/win state machine with board_reset.
module breakout_hit_arbiter #(
  parameter int unsigned NCOL         = 8,
  parameter int unsigned CNT_W        = 6,
  parameter int unsigned SCORE_W      = 10,
  parameter int unsigned LIVES        = 3,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned WIN_SCORE    = 360
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  frame_tick,
  input  logic                  start_btn,
  input  logic                  ball_miss,
  breakout_hit_arbiter_if.slave hit_bus,
  output logic [SCORE_W-1:0]    score,
  output logic [2:0]            lives,
  output logic                  ball_enable,
  output logic                  board_reset,
  output logic [2:0]            game_state
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_LOST  = 3'd3,
    ST_WON   = 3'd4,
    ST_OVER  = 3'd5
  } state_t;

  localparam logic [2:0]  LIVES_INIT = 3'(LIVES);
  localparam logic [7:0]  SERVE_LAST = 8'(SERVE_FRAMES - 1);
  localparam logic [2:0]  GRANT_INIT = 3'(NCOL - 1);
  localparam logic [31:0] SCORE_MAX  = (32'd1 << SCORE_W) - 32'd1;

  state_t             state_q, state_d;
  logic [2:0]         lives_q, lives_d;
  logic [7:0]         serve_cnt_q, serve_cnt_d;
  logic               cooldown_q, cooldown_d;
  logic [2:0]         grant_col_q, grant_col_d;
  logic [3:0]         bounce_q, bounce_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               board_reset_q, board_reset_d;

  logic [7:0]  hit_u8, hit_d8, hit_l8, hit_r8, req;
  logic        found, grant;
  logic [2:0]  grant_idx, pos;
  logic [31:0] sum;

  // Round-robin search starts one past the last grant and wraps modulo NCOL.
  always_comb begin
    hit_u8 = '0;
    hit_d8 = '0;
    hit_l8 = '0;
    hit_r8 = '0;
    hit_u8[NCOL-1:0] = hit_bus.col_hit_u;
    hit_d8[NCOL-1:0] = hit_bus.col_hit_d;
    hit_l8[NCOL-1:0] = hit_bus.col_hit_l;
    hit_r8[NCOL-1:0] = hit_bus.col_hit_r;
    req       = hit_u8 | hit_d8 | hit_l8 | hit_r8;
    found     = 1'b0;
    grant_idx = grant_col_q;
    pos       = '0;
    for (int unsigned k = 1; k <= NCOL; k++) begin
      pos = 3'((32'(grant_col_q) + k) % NCOL);
      if (!found && req[pos]) begin
        found     = 1'b1;
        grant_idx = pos;
      end
    end
    grant = found && (state_q == ST_PLAY) && !cooldown_q && !ball_miss;
  end

  always_comb begin
    sum = '0;
    for (int unsigned i = 0; i < NCOL; i++) begin
      sum = sum + 32'(hit_bus.col_count[i*CNT_W +: CNT_W]);
    end
    score_d = (sum > SCORE_MAX) ? '1 : sum[SCORE_W-1:0];
  end

  always_comb begin
    state_d       = state_q;
    lives_d       = lives_q;
    serve_cnt_d   = serve_cnt_q;
    cooldown_d    = cooldown_q;
    grant_col_d   = grant_col_q;
    bounce_d      = '0;
    board_reset_d = 1'b0;

    if (frame_tick) cooldown_d = 1'b0;
    // A grant in the tick cycle itself re-arms the cooldown for the new frame.
    if (grant) begin
      cooldown_d  = 1'b1;
      grant_col_d = grant_idx;
      bounce_d    = {hit_u8[grant_idx], hit_d8[grant_idx],
                     hit_l8[grant_idx], hit_r8[grant_idx]};
    end

    unique case (state_q)
      ST_IDLE, ST_WON, ST_OVER: begin
        if (start_btn) begin
          state_d       = ST_SERVE;
          board_reset_d = 1'b1;
          lives_d       = LIVES_INIT;
          serve_cnt_d   = '0;
          cooldown_d    = 1'b0;
        end
      end
      ST_SERVE: begin
        if (frame_tick) begin
          if (serve_cnt_q == SERVE_LAST) begin
            state_d     = ST_PLAY;
            serve_cnt_d = '0;
          end else begin
            serve_cnt_d = serve_cnt_q + 8'd1;
          end
        end
      end
      ST_PLAY: begin
        if (ball_miss)                         state_d = ST_LOST;
        else if (32'(score_q) >= WIN_SCORE)    state_d = ST_WON;
      end
      ST_LOST: begin
        lives_d     = lives_q - 3'd1;
        serve_cnt_d = '0;
        cooldown_d  = 1'b0;
        state_d     = (lives_q == 3'd1) ? ST_OVER : ST_SERVE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      lives_q       <= LIVES_INIT;
      serve_cnt_q   <= '0;
      cooldown_q    <= 1'b0;
      grant_col_q   <= GRANT_INIT;
      bounce_q      <= '0;
      score_q       <= '0;
      board_reset_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      lives_q       <= lives_d;
      serve_cnt_q   <= serve_cnt_d;
      cooldown_q    <= cooldown_d;
      grant_col_q   <= grant_col_d;
      bounce_q      <= bounce_d;
      score_q       <= score_d;
      board_reset_q <= board_reset_d;
    end
  end

  assign hit_bus.bounce_u  = bounce_q[3];
  assign hit_bus.bounce_d  = bounce_q[2];
  assign hit_bus.bounce_l  = bounce_q[1];
  assign hit_bus.bounce_r  = bounce_q[0];
  assign hit_bus.grant_col = grant_col_q;
  assign score             = score_q;
  assign lives             = lives_q;
  assign ball_enable       = (state_q == ST_PLAY);
  assign board_reset       = board_reset_q;
  assign game_state        = state_q;

endmodule

// File: tb/tb_breakout_hit_arbiter.sv
// Directed bench for breakout_hit_arbiter: serve, grants, round-robin,
// miss priority, win, and mid-game reset.
module tb_breakout_hit_arbiter;
  logic       clk = 1'b0;
  logic       reset, frame_tick, start_btn, ball_miss;
  logic [9:0] score;
  logic [2:0] lives, game_state;
  logic       ball_enable, board_reset;
  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  breakout_hit_arbiter_if #(.NCOL(8), .CNT_W(6)) hb ();

  breakout_hit_arbiter #(
    .NCOL(8), .CNT_W(6), .SCORE_W(10), .LIVES(3), .SERVE_FRAMES(60), .WIN_SCORE(360)
  ) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .start_btn(start_btn),
    .ball_miss(ball_miss), .hit_bus(hb), .score(score), .lives(lives),
    .ball_enable(ball_enable), .board_reset(board_reset), .game_state(game_state)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_col(input int unsigned idx, input int unsigned val);
    hb.col_count[idx*6 +: 6] = 6'(val);
  endtask

  task automatic run_serve();
    for (int i = 0; i < 60; i++) begin
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; frame_tick = 1'b0; start_btn = 1'b0; ball_miss = 1'b0;
    hb.col_hit_u = '0; hb.col_hit_d = '0; hb.col_hit_l = '0; hb.col_hit_r = '0;
    hb.col_count = '0;
    set_col(0, 5);
    repeat (2) @(negedge clk);
    vectors++; if (game_state !== 3'd0) begin miscompares++; $display("FAIL reset_state: got %0d want 0", game_state); end
    vectors++; if (lives !== 3'd3) begin miscompares++; $display("FAIL reset_lives: got %0d want 3", lives); end
    vectors++; if (score !== 10'd0) begin miscompares++; $display("FAIL reset_score: got %0d want 0", score); end
    vectors++; if (hb.grant_col !== 3'd7) begin miscompares++; $display("FAIL reset_grant_col: got %0d want 7", hb.grant_col); end
    vectors++;
    if ({hb.bounce_u, hb.bounce_d, hb.bounce_l, hb.bounce_r, ball_enable, board_reset} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b want 000000",
               {hb.bounce_u, hb.bounce_d, hb.bounce_l, hb.bounce_r, ball_enable, board_reset});
    end
    reset = 1'b0;
    @(negedge clk);
    vectors++; if (score !== 10'd5) begin miscompares++; $display("FAIL idle_score: got %0d want 5", score); end
    set_col(0, 0);
  endtask

  task automatic test_serve();
    start_btn = 1'b1;
    @(negedge clk);
    start_btn = 1'b0;
    vectors++; if (game_state !== 3'd1) begin miscompares++; $display("FAIL start_state: got %0d want 1", game_state); end
    vectors++; if (board_reset !== 1'b1) begin miscompares++; $display("FAIL start_board_reset: got %b want 1", board_reset); end
    vectors++; if (ball_enable !== 1'b0) begin miscompares++; $display("FAIL serve_ball_enable: got %b want 0", ball_enable); end
    @(negedge clk);
    vectors++; if (board_reset !== 1'b0) begin miscompares++; $display("FAIL board_reset_width: got %b want 0", board_reset); end
    for (int i = 0; i < 60; i++) begin
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      if (i == 58) begin
        vectors++; if (game_state !== 3'd1) begin miscompares++; $display("FAIL serve_59_ticks: got %0d want 1", game_state); end
      end
      @(negedge clk);
    end
    vectors++; if (game_state !== 3'd2) begin miscompares++; $display("FAIL serve_to_play: got %0d want 2", game_state); end
    vectors++; if (ball_enable !== 1'b1) begin miscompares++; $display("FAIL play_ball_enable: got %b want 1", ball_enable); end
  endtask

  task automatic test_single_grant();
    hb.col_hit_d = 8'h04; hb.col_hit_r = 8'h04;
    @(negedge clk);
    hb.col_hit_d = '0; hb.col_hit_r = '0;
    vectors++;
    if ({hb.bounce_u, hb.bounce_d, hb.bounce_l, hb.bounce_r} !== 4'b0101) begin
      miscompares++;
      $display("FAIL grant_bounce: got %b want 0101", {hb.bounce_u, hb.bounce_d, hb.bounce_l, hb.bounce_r});
    end
    vectors++; if (hb.grant_col !== 3'd2) begin miscompares++; $display("FAIL grant_col: got %0d want 2", hb.grant_col); end
    @(negedge clk);
    vectors++;
    if ({hb.bounce_u, hb.bounce_d, hb.bounce_l, hb.bounce_r} !== 4'b0000) begin
      miscompares++;
      $display("FAIL grant_pulse_width: got %b want 0000", {hb.bounce_u, hb.bounce_d, hb.bounce_l, hb.bounce_r});
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_col [3];
    exp_col[0] = 3'd3; exp_col[1] = 3'd0; exp_col[2] = 3'd3;
    hb.col_hit_u = 8'h09;
    for (int g = 0; g < 3; g++) begin
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      vectors++;
      if ({hb.bounce_u, hb.bounce_d, hb.bounce_l, hb.bounce_r} !== 4'b0000) begin
        miscompares++;
        $display("FAIL rr_tick_cycle: got %b want 0000", {hb.bounce_u, hb.bounce_d, hb.bounce_l, hb.bounce_r});
      end
      @(negedge clk);
      vectors++;
      if ({hb.bounce_u, hb.bounce_d, hb.bounce_l, hb.bounce_r} !== 4'b1000) begin
        miscompares++;
        $display("FAIL rr_bounce: got %b want 1000", {hb.bounce_u, hb.bounce_d, hb.bounce_l, hb.bounce_r});
      end
      vectors++; if (hb.grant_col !== exp_col[g]) begin miscompares++; $display("FAIL rr_grant_col: got %0d want %0d", hb.grant_col, exp_col[g]); end
      for (int j = 0; j < 3; j++) begin
        @(negedge clk);
        vectors++;
        if ({hb.bounce_u, hb.bounce_d, hb.bounce_l, hb.bounce_r} !== 4'b0000) begin
          miscompares++;
          $display("FAIL rr_cooldown_drop: got %b want 0000", {hb.bounce_u, hb.bounce_d, hb.bounce_l, hb.bounce_r});
        end
      end
    end
    hb.col_hit_u = '0;
    @(negedge clk);
  endtask

  task automatic test_miss_priority();
    for (int m = 0; m < 3; m++) begin
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      ball_miss = 1'b1; hb.col_hit_l = 8'h01;
      @(negedge clk);
      ball_miss = 1'b0; hb.col_hit_l = '0;
      vectors++; if (game_state !== 3'd3) begin miscompares++; $display("FAIL miss_lost_state: got %0d want 3", game_state); end
      vectors++; if (hb.bounce_l !== 1'b0) begin miscompares++; $display("FAIL miss_no_bounce: got %b want 0", hb.bounce_l); end
      vectors++; if (hb.grant_col !== 3'd3) begin miscompares++; $display("FAIL miss_no_grant: got %0d want 3", hb.grant_col); end
      vectors++; if (ball_enable !== 1'b0) begin miscompares++; $display("FAIL lost_ball_enable: got %b want 0", ball_enable); end
      @(negedge clk);
      vectors++; if (lives !== 3'(2 - m)) begin miscompares++; $display("FAIL miss_lives: got %0d want %0d", lives, 2 - m); end
      if (m < 2) begin
        vectors++; if (game_state !== 3'd1) begin miscompares++; $display("FAIL lost_to_serve: got %0d want 1", game_state); end
        run_serve();
        vectors++; if (game_state !== 3'd2) begin miscompares++; $display("FAIL reserve_play: got %0d want 2", game_state); end
      end else begin
        vectors++; if (game_state !== 3'd5) begin miscompares++; $display("FAIL lost_to_over: got %0d want 5", game_state); end
        vectors++; if (ball_enable !== 1'b0) begin miscompares++; $display("FAIL over_ball_enable: got %b want 0", ball_enable); end
      end
    end
  endtask

  task automatic test_win();
    start_btn = 1'b1;
    @(negedge clk);
    start_btn = 1'b0;
    vectors++; if (game_state !== 3'd1) begin miscompares++; $display("FAIL over_restart_state: got %0d want 1", game_state); end
    vectors++; if (board_reset !== 1'b1) begin miscompares++; $display("FAIL over_restart_board_reset: got %b want 1", board_reset); end
    vectors++; if (lives !== 3'd3) begin miscompares++; $display("FAIL over_restart_lives: got %0d want 3", lives); end
    start_btn = 1'b1;
    @(negedge clk);
    start_btn = 1'b0;
    @(negedge clk);
    vectors++; if (board_reset !== 1'b0) begin miscompares++; $display("FAIL serve_start_ignored: got %b want 0", board_reset); end
    run_serve();
    vectors++; if (game_state !== 3'd2) begin miscompares++; $display("FAIL win_play: got %0d want 2", game_state); end
    for (int i = 0; i < 5; i++) set_col(i, 63);
    set_col(5, 40);
    @(negedge clk);
    @(negedge clk);
    vectors++; if (score !== 10'd355) begin miscompares++; $display("FAIL score_355: got %0d want 355", score); end
    vectors++; if (game_state !== 3'd2) begin miscompares++; $display("FAIL below_win_state: got %0d want 2", game_state); end
    set_col(5, 45);
    @(negedge clk);
    vectors++; if (score !== 10'd360) begin miscompares++; $display("FAIL score_360: got %0d want 360", score); end
    vectors++; if (game_state !== 3'd2) begin miscompares++; $display("FAIL win_latency: got %0d want 2", game_state); end
    @(negedge clk);
    vectors++; if (game_state !== 3'd4) begin miscompares++; $display("FAIL won_state: got %0d want 4", game_state); end
    vectors++; if (ball_enable !== 1'b0) begin miscompares++; $display("FAIL won_ball_enable: got %b want 0", ball_enable); end
    start_btn = 1'b1;
    @(negedge clk);
    start_btn = 1'b0;
    hb.col_count = '0;
    vectors++; if (game_state !== 3'd1) begin miscompares++; $display("FAIL won_restart_state: got %0d want 1", game_state); end
    vectors++; if (board_reset !== 1'b1) begin miscompares++; $display("FAIL won_restart_board_reset: got %b want 1", board_reset); end
    vectors++; if (lives !== 3'd3) begin miscompares++; $display("FAIL won_restart_lives: got %0d want 3", lives); end
    @(negedge clk);
    @(negedge clk);
    vectors++; if (score !== 10'd0) begin miscompares++; $display("FAIL score_cleared: got %0d want 0", score); end
  endtask

  task automatic test_reset_mid_play();
    run_serve();
    vectors++; if (game_state !== 3'd2) begin miscompares++; $display("FAIL midreset_play: got %0d want 2", game_state); end
    set_col(0, 10);
    @(negedge clk);
    @(negedge clk);
    vectors++; if (score !== 10'd10) begin miscompares++; $display("FAIL midreset_score: got %0d want 10", score); end
    ball_miss = 1'b1;
    @(negedge clk);
    ball_miss = 1'b0;
    @(negedge clk);
    vectors++; if (lives !== 3'd2) begin miscompares++; $display("FAIL midreset_lives_before: got %0d want 2", lives); end
    run_serve();
    hb.col_hit_r = 8'h20;
    @(negedge clk);
    hb.col_hit_r = '0;
    vectors++; if (hb.grant_col !== 3'd5) begin miscompares++; $display("FAIL midreset_grant: got %0d want 5", hb.grant_col); end
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    hb.col_hit_r = 8'h02;
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if ({hb.bounce_u, hb.bounce_d, hb.bounce_l, hb.bounce_r} !== 4'b0000) begin
      miscompares++;
      $display("FAIL midreset_bounce: got %b want 0000", {hb.bounce_u, hb.bounce_d, hb.bounce_l, hb.bounce_r});
    end
    vectors++; if (game_state !== 3'd0) begin miscompares++; $display("FAIL midreset_state: got %0d want 0", game_state); end
    vectors++; if (score !== 10'd0) begin miscompares++; $display("FAIL midreset_score_clear: got %0d want 0", score); end
    vectors++; if (lives !== 3'd3) begin miscompares++; $display("FAIL midreset_lives: got %0d want 3", lives); end
    vectors++; if (hb.grant_col !== 3'd7) begin miscompares++; $display("FAIL midreset_grant_col: got %0d want 7", hb.grant_col); end
    vectors++; if (ball_enable !== 1'b0) begin miscompares++; $display("FAIL midreset_ball_enable: got %b want 0", ball_enable); end
    reset = 1'b0;
    hb.col_hit_r = '0;
    hb.col_count = '0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_serve();
    test_single_grant();
    test_round_robin();
    test_miss_priority();
    test_win();
    test_reset_mid_play();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
